peg_grader: RTL

- Parametrised sequential grader for the code-guessing game.
- Computes in one pass the exact-position match count (znarly) and the right-colour/wrong-position count (zood) for one guess against the master code.
- Generalises the fixed 4-peg, zood-only grader: any peg count, any colour width, both scores, with fixed and predictable latency.
- Sits between the guess-entry logic and the score display/round controller.

---
 rtl/peg_grader.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/peg_grader.sv
// ---------------------------------------------------------------------------
// peg_grader
//   Sequential grader for the code-guessing game. For one guess it computes
//   the exact-position match count (znarly) and the right-colour /
//   wrong-position count (zood) against the master code. The latency is fixed.
//
//   Sequence: IDLE -> EXACT (NUM_PEGS cycles) -> COLOR (NUM_PEGS^2 cycles)
//             -> DONE (1 cycle) -> IDLE.
//
//   Ports
//     CLOCK_50      in   system clock, rising edge
//     reset         in   asynchronous, active-high reset
//     start         in   grade request, sampled only in IDLE
//     master        in   master code, peg k at [k*COLOR_W +: COLOR_W]
//     guess         in   guess code, same packing
//     busy          out  high from the cycle after accept through DONE
//     done          out  one-cycle pulse, results valid
//     znarly_count  out  exact matches
//     zood_count    out  colour-only matches
//     exact_mask    out  bit k: master peg k == guess peg k
//     used_mask     out  bit j: master peg j consumed by a colour-only match
//     win           out  (PEG_GRADER_WIN_EN only) all pegs exact
//
//   Optional feature macro: PEG_GRADER_WIN_EN
//     When it is defined, the module adds the win output. If every peg is an
//     exact match at the end of EXACT, the FSM skips COLOR and the latency
//     becomes NUM_PEGS+1.
// ---------------------------------------------------------------------------
module peg_grader #(
  parameter int NUM_PEGS = 4,
  parameter int COLOR_W  = 3,
  parameter int CNT_W    = $clog2(NUM_PEGS + 1)
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NUM_PEGS*COLOR_W-1:0]   master,
  input  logic [NUM_PEGS*COLOR_W-1:0]   guess,
  output logic                          busy,
  output logic                          done,
  output logic [CNT_W-1:0]              znarly_count,
  output logic [CNT_W-1:0]              zood_count,
  output logic [NUM_PEGS-1:0]           exact_mask,
  output logic [NUM_PEGS-1:0]           used_mask
`ifdef PEG_GRADER_WIN_EN
  ,
  output logic                          win
`endif
);

  localparam int IDX_W = (NUM_PEGS > 1) ? $clog2(NUM_PEGS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_PEGS - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_PEGS);

  typedef enum logic [1:0] {IDLE, EXACT, COLOR, DONE} state_t;

  state_t                        state_q, state_d;
  logic [NUM_PEGS*COLOR_W-1:0]   m_q, m_d, g_q, g_d;
  logic [IDX_W-1:0]              k_q, k_d, i_q, i_d, j_q, j_d;
  logic                          matched_q, matched_d;
  logic [NUM_PEGS-1:0]           ex_acc_q, ex_acc_d, used_acc_q, used_acc_d;
  logic [CNT_W-1:0]              zn_acc_q, zn_acc_d, zo_acc_q, zo_acc_d;
  logic [CNT_W-1:0]              znarly_count_q, znarly_count_d;
  logic [CNT_W-1:0]              zood_count_q, zood_count_d;
  logic [NUM_PEGS-1:0]           exact_mask_q, exact_mask_d;
  logic [NUM_PEGS-1:0]           used_mask_q, used_mask_d;
  logic                          win_q, win_d;

  // Unpack the captured codes so pegs can be selected by index.
  logic [COLOR_W-1:0] m_peg [NUM_PEGS];
  logic [COLOR_W-1:0] g_peg [NUM_PEGS];

  for (genvar p = 0; p < NUM_PEGS; p++) begin : g_unpack
    assign m_peg[p] = m_q[p*COLOR_W +: COLOR_W];
    assign g_peg[p] = g_q[p*COLOR_W +: COLOR_W];
  end

  logic             exact_hit;
  logic [CNT_W-1:0] zn_inc;
  logic             consume;

  assign exact_hit = (m_peg[k_q] == g_peg[k_q]);
  assign zn_inc    = zn_acc_q + CNT_W'(exact_hit);
  // Guess peg i takes the lowest-index eligible master peg j. Pegs that are
  // already exact on either side never take part in colour-only matching.
  assign consume   = (state_q == COLOR) & ~ex_acc_q[i_q] & ~ex_acc_q[j_q] &
                     ~used_acc_q[j_q] & ~matched_q & (g_peg[i_q] == m_peg[j_q]);

  // State and datapath registers
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      m_q            <= '0;
      g_q            <= '0;
      k_q            <= '0;
      i_q            <= '0;
      j_q            <= '0;
      matched_q      <= 1'b0;
      ex_acc_q       <= '0;
      used_acc_q     <= '0;
      zn_acc_q       <= '0;
      zo_acc_q       <= '0;
      znarly_count_q <= '0;
      zood_count_q   <= '0;
      exact_mask_q   <= '0;
      used_mask_q    <= '0;
      win_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      m_q            <= m_d;
      g_q            <= g_d;
      k_q            <= k_d;
      i_q            <= i_d;
      j_q            <= j_d;
      matched_q      <= matched_d;
      ex_acc_q       <= ex_acc_d;
      used_acc_q     <= used_acc_d;
      zn_acc_q       <= zn_acc_d;
      zo_acc_q       <= zo_acc_d;
      znarly_count_q <= znarly_count_d;
      zood_count_q   <= zood_count_d;
      exact_mask_q   <= exact_mask_d;
      used_mask_q    <= used_mask_d;
      win_q          <= win_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = EXACT;
      EXACT: begin
        if (k_q == LAST) begin
`ifdef PEG_GRADER_WIN_EN
          state_d = (zn_inc == FULL) ? DONE : COLOR;
`else
          state_d = COLOR;
`endif
        end
      end
      COLOR: if ((i_q == LAST) && (j_q == LAST)) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture, accumulate, and load the outputs on entry to DONE
  always_comb begin
    m_d            = m_q;
    g_d            = g_q;
    k_d            = k_q;
    i_d            = i_q;
    j_d            = j_q;
    matched_d      = matched_q;
    ex_acc_d       = ex_acc_q;
    used_acc_d     = used_acc_q;
    zn_acc_d       = zn_acc_q;
    zo_acc_d       = zo_acc_q;
    znarly_count_d = znarly_count_q;
    zood_count_d   = zood_count_q;
    exact_mask_d   = exact_mask_q;
    used_mask_d    = used_mask_q;
    win_d          = win_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          m_d        = master;
          g_d        = guess;
          k_d        = '0;
          i_d        = '0;
          j_d        = '0;
          matched_d  = 1'b0;
          ex_acc_d   = '0;
          used_acc_d = '0;
          zn_acc_d   = '0;
          zo_acc_d   = '0;
        end
      end
      EXACT: begin
        if (exact_hit) ex_acc_d[k_q] = 1'b1;
        zn_acc_d = zn_inc;
        if (k_q == LAST) begin
          k_d       = '0;
          i_d       = '0;
          j_d       = '0;
          matched_d = 1'b0;
        end else begin
          k_d = k_q + IDX_W'(1);
        end
      end
      COLOR: begin
        if (consume) begin
          used_acc_d[j_q] = 1'b1;
          matched_d       = 1'b1;
          zo_acc_d        = zo_acc_q + CNT_W'(1);
        end
        if (j_q == LAST) begin
          // Moving to the next guess peg: its match flag starts clear.
          j_d       = '0;
          i_d       = (i_q == LAST) ? '0 : i_q + IDX_W'(1);
          matched_d = 1'b0;
        end else begin
          j_d = j_q + IDX_W'(1);
        end
      end
      default: ;
    endcase

    // Outputs take the final accumulator values on the edge into DONE, so
    // they are already valid during the done pulse.
    if (state_d == DONE && state_q != DONE) begin
      znarly_count_d = zn_acc_d;
      zood_count_d   = zo_acc_d;
      exact_mask_d   = ex_acc_d;
      used_mask_d    = used_acc_d;
      win_d          = (zn_acc_d == FULL);
    end
  end

  // Output logic
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  assign znarly_count = znarly_count_q;
  assign zood_count   = zood_count_q;
  assign exact_mask   = exact_mask_q;
  assign used_mask    = used_mask_q;

`ifdef PEG_GRADER_WIN_EN
  assign win = win_q;
`else
  logic unused_win;
  assign unused_win = win_q;
`endif

endmodule
